// File: rtl/pa_spsram_pkg.sv
// Shared definitions for the self-initialising single-port SRAM wrapper.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package pa_spsram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_INIT  = 2'd1,
        ST_READY = 2'd2
    } init_state_e;

    // Bits covered by one write-enable lane.
    function automatic int lane_width(input int data_width, input int we_width);
        return data_width / we_width;
    endfunction

endpackage

// File: rtl/pa_f_spsram_gen.sv
// Single-port storage array with per-lane active-low write enables, no reset.
// Latency: synchronous read, Q valid one cycle after a CEN=0/GWEN=1 edge.
// Backpressure: none; Q holds its last read value on writes and idle cycles.
module pa_f_spsram_gen
    import pa_spsram_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 4,
    parameter int WE_WIDTH   = 4
) (
    input  logic                  CLK,
    input  logic [ADDR_WIDTH-1:0] A,
    input  logic                  CEN,
    input  logic                  GWEN,
    input  logic [WE_WIDTH-1:0]   WEN,
    input  logic [DATA_WIDTH-1:0] D,
    output logic [DATA_WIDTH-1:0] Q
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int LW    = lane_width(DATA_WIDTH, WE_WIDTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge CLK) begin
        if (!CEN) begin
            if (GWEN) begin
                Q <= mem[A];
            end else begin
                for (int i = 0; i < WE_WIDTH; i++) begin
                    if (!WEN[i]) begin
                        mem[A][i*LW +: LW] <= D[i*LW +: LW];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/pa_spsram_init_gen.sv
// Single-port SRAM that writes INIT_VALUE to every entry after reset or init_req, then serves accesses.
// Latency: read 1 cycle (2 with PA_SPSRAM_OREG_EN); init takes 2^ADDR_WIDTH cycles after entering INIT.
// Backpressure: none; accesses presented while init_done=0 are dropped, not stalled.
module pa_spsram_init_gen
    import pa_spsram_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    DATA_WIDTH = 4,
    parameter int                    WE_WIDTH   = 4,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                  CLK,
    input  logic                  cpurst_b,
    input  logic [ADDR_WIDTH-1:0] A,
    input  logic                  CEN,
    input  logic                  GWEN,
    input  logic [WE_WIDTH-1:0]   WEN,
    input  logic [DATA_WIDTH-1:0] D,
    input  logic                  init_req,
    output logic [DATA_WIDTH-1:0] Q,
    output logic                  init_done
);

    init_state_e           state, state_nxt;
    logic [ADDR_WIDTH-1:0] cnt, cnt_nxt;

    logic                  mem_cen;
    logic                  mem_gwen;
    logic [WE_WIDTH-1:0]   mem_wen;
    logic [ADDR_WIDTH-1:0] mem_a;
    logic [DATA_WIDTH-1:0] mem_d;
    logic [DATA_WIDTH-1:0] mem_q;
    logic                  rd_fire;

    always_ff @(posedge CLK or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        mem_cen   = 1'b1;
        mem_gwen  = 1'b1;
        mem_wen   = '1;
        mem_a     = A;
        mem_d     = D;
        case (state)
            ST_IDLE: begin
                state_nxt = ST_INIT;
                cnt_nxt   = '0;
            end
            ST_INIT: begin
                mem_cen  = 1'b0;
                mem_gwen = 1'b0;
                mem_wen  = '0;
                mem_a    = cnt;
                mem_d    = INIT_VALUE;
                cnt_nxt  = cnt + 1'b1;
                // A restart request wins over completing the sweep.
                if (init_req) begin
                    cnt_nxt = '0;
                end else if (&cnt) begin
                    state_nxt = ST_READY;
                end
            end
            ST_READY: begin
                mem_cen  = CEN;
                mem_gwen = GWEN;
                mem_wen  = WEN;
                if (init_req) begin
                    state_nxt = ST_INIT;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign rd_fire   = (state == ST_READY) && !CEN && GWEN;
    assign init_done = (state == ST_READY);

    pa_f_spsram_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .WE_WIDTH   (WE_WIDTH)
    ) u_mem (
        .CLK  (CLK),
        .A    (mem_a),
        .CEN  (mem_cen),
        .GWEN (mem_gwen),
        .WEN  (mem_wen),
        .D    (mem_d),
        .Q    (mem_q)
    );

`ifdef PA_SPSRAM_OREG_EN
    logic                  rd_pend;
    logic [DATA_WIDTH-1:0] q_oreg;

    always_ff @(posedge CLK or negedge cpurst_b) begin
        if (!cpurst_b) begin
            rd_pend <= 1'b0;
            q_oreg  <= '0;
        end else begin
            rd_pend <= rd_fire;
            if (rd_pend) begin
                q_oreg <= mem_q;
            end
        end
    end

    assign Q = q_oreg;
`else
    // The array output has no reset; mask it until a read lands after reset.
    logic rd_seen;

    always_ff @(posedge CLK or negedge cpurst_b) begin
        if (!cpurst_b) begin
            rd_seen <= 1'b0;
        end else if (rd_fire) begin
            rd_seen <= 1'b1;
        end
    end

    assign Q = rd_seen ? mem_q : '0;
`endif

endmodule

// File: tb/tb_pa_spsram_init_gen.sv
// Randomised bench for pa_spsram_init_gen against an array-level reference model.
module tb_pa_spsram_init_gen;

    localparam logic [3:0] INIT_V = 4'h9;
`ifdef PA_SPSRAM_OREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic       CLK;
    logic       cpurst_b;
    logic [7:0] A;
    logic       CEN;
    logic       GWEN;
    logic [3:0] WEN;
    logic [3:0] D;
    logic       init_req;
    logic [3:0] Q;
    logic       init_done;

    pa_spsram_init_gen #(
        .ADDR_WIDTH (8),
        .DATA_WIDTH (4),
        .WE_WIDTH   (4),
        .INIT_VALUE (INIT_V)
    ) dut (
        .CLK       (CLK),
        .cpurst_b  (cpurst_b),
        .A         (A),
        .CEN       (CEN),
        .GWEN      (GWEN),
        .WEN       (WEN),
        .D         (D),
        .init_req  (init_req),
        .Q         (Q),
        .init_done (init_done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: array contents, readiness and remaining init cycles.
    logic [3:0] mem_m [256];
    bit         idle_m;
    bit         rdy_m;
    int         init_left;
    logic [3:0] q_m;
    bit         pend_m;
    logic [3:0] pend_dat;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic model_fill();
        for (int i = 0; i < 256; i++) mem_m[i] = INIT_V;
    endtask

    task automatic cycle(input bit cen, input bit gwen, input logic [3:0] wen,
                         input logic [7:0] a, input logic [3:0] d, input bit ireq);
        CEN = cen; GWEN = gwen; WEN = wen; A = a; D = d; init_req = ireq;
        @(posedge CLK);
        #1;
        if (pend_m) q_m = pend_dat;
        pend_m = 1'b0;
        if (idle_m) begin
            idle_m    = 1'b0;
            init_left = 256;
            model_fill();
        end else if (!rdy_m) begin
            if (ireq) init_left = 256;
            else begin
                init_left--;
                if (init_left == 0) rdy_m = 1'b1;
            end
        end else begin
            if (!cen) begin
                if (gwen) begin
                    if (LAT == 2) begin
                        pend_m   = 1'b1;
                        pend_dat = mem_m[a];
                    end else begin
                        q_m = mem_m[a];
                    end
                end else begin
                    for (int i = 0; i < 4; i++) if (!wen[i]) mem_m[a][i] = d[i];
                end
            end
            if (ireq) begin
                rdy_m     = 1'b0;
                init_left = 256;
                model_fill();
            end
        end
        chk("init_done", init_done, rdy_m);
        chk("q", Q, q_m);
    endtask

    task automatic idle_cyc();
        cycle(1'b1, 1'b1, 4'hF, 8'h00, 4'h0, 1'b0);
    endtask

    task automatic read_cyc(input logic [7:0] a);
        cycle(1'b0, 1'b1, 4'hF, a, 4'h0, 1'b0);
        repeat (LAT - 1) idle_cyc();
    endtask

    task automatic rand_acc(input bit ireq);
        logic [7:0] a;
        a = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
        cycle(($urandom_range(0, 3) == 0), 1'($urandom), 4'($urandom), a, 4'($urandom), ireq);
    endtask

    task automatic do_reset();
        cpurst_b = 1'b0;
        #2;
        chk("rst_q", Q, 0);
        chk("rst_done", init_done, 0);
        idle_m = 1'b1; rdy_m = 1'b0; q_m = '0; pend_m = 1'b0;
        @(negedge CLK);
        cpurst_b = 1'b1;
    endtask

    task automatic wait_init(input string tag, input int exp_n);
        int n;
        n = 0;
        do begin
            rand_acc(1'b0);
            n++;
        end while (!init_done && n < 600);
        chk(tag, n, exp_n);
    endtask

    initial begin
        CEN = 1'b1; GWEN = 1'b1; WEN = 4'hF; A = '0; D = '0; init_req = 1'b0;
        do_reset();
        wait_init("init_len", 257);

        for (int i = 0; i < 8; i++) begin
            read_cyc(8'($urandom));
            chk("rd_init", Q, INIT_V);
        end

        cycle(1'b0, 1'b0, 4'b0000, 8'h12, 4'hA, 1'b0);
        read_cyc(8'h12);
        chk("rd_full_wr", Q, 4'hA);

        cycle(1'b0, 1'b0, 4'b1010, 8'h12, 4'h5, 1'b0);
        read_cyc(8'h12);
        chk("rd_lane_wr", Q, 4'hF);

        cycle(1'b0, 1'b0, 4'b1111, 8'h12, 4'h0, 1'b0);
        read_cyc(8'h12);
        chk("rd_noop_wr", Q, 4'hF);

        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'($urandom), 4'($urandom), 8'($urandom), 4'($urandom), 1'b0);
            chk("hold_cen", Q, 4'hF);
        end
        cycle(1'b0, 1'b0, 4'b0000, 8'h13, 4'h2, 1'b0);
        chk("hold_wr", Q, 4'hF);
        idle_cyc();
        chk("hold_wr2", Q, 4'hF);

        repeat (400) rand_acc(1'b0);

        cycle(1'b0, 1'b0, 4'b0000, 8'h20, 4'h3, 1'b1);
        chk("reinit_drop", init_done, 0);
        wait_init("reinit_len", 256);
        read_cyc(8'h20);
        chk("rd_reinit", Q, INIT_V);
        read_cyc(8'h12);
        chk("rd_reinit12", Q, INIT_V);

        idle_cyc();
        cycle(1'b1, 1'b1, 4'hF, 8'h00, 4'h0, 1'b1);
        repeat (50) rand_acc(1'b0);
        cycle(1'b0, 1'b0, 4'b0000, 8'h05, 4'h1, 1'b1);
        wait_init("restart_len", 256);

        repeat (100) rand_acc(1'b0);
        read_cyc(8'h30);
        chk("rd_pre_rst", Q, mem_m[8'h30]);

        do_reset();
        repeat (101) rand_acc(1'b0);
        do_reset();
        wait_init("rst_init_len", 257);
        for (int i = 0; i < 4; i++) begin
            read_cyc(8'($urandom));
            chk("rd_post_rst", Q, INIT_V);
        end
        repeat (200) rand_acc(1'b0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
